exc_flush_ctrl: RTL and testbench
=================================

# exc_flush_ctrl

Sequencer that turns an exception, interrupt or ERET seen at the MEM stage into an ordered redirect: it blocks new memory issue, drains outstanding data-SRAM transactions and the divider, commits exception state to CP0, flushes the pipeline and hands the redirect PC to IF over a valid/ready handshake. It sits between the MEM stage, the CP0 register file and the fetch unit, and is the only source of `flush` and exception redirects.

## Interface
- `EXC_VECTOR`, 32'hBFC00380: redirect target for exceptions and interrupts.
- `OUTST_W`, 3: width of the outstanding-transaction counter; max count is 2^OUTST_W-1.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  MEM stage holds a valid instruction.
- `mem_pc`  in  32  PC of the MEM instruction.
- `mem_bd`  in  1  MEM instruction is in a delay slot.
- `exc_req`  in  1  MEM instruction raised a synchronous exception.
- `exc_code`  in  5  ExcCode of that exception.
- `exc_badv_valid`  in  1  exception carries a bad address (AdEL/AdES).
- `exc_badvaddr`  in  32  offending address.
- `int_pending`  in  1  CP0 masked interrupt, already qualified by IE and !EXL.
- `eret_req`  in  1  MEM instruction is ERET.
- `cp0_epc`  in  32  current CP0 EPC.
- `mem_issue`  in  1  a data-SRAM request is accepted this cycle.
- `mem_done`  in  1  a data-SRAM response returns this cycle.
- `div_busy`  in  1  divider is mid-operation.
- `redirect_ready`  in  1  IF accepts the redirect.
- `busy`  out  1  controller not IDLE; upstream stages hold.
- `mem_issue_block`  out  1  memory issue forbidden.
- `flush`  out  1  one-cycle pipeline flush pulse.
- `cp0_commit`  out  1  one-cycle pulse: CP0 latches EPC/Cause.ExcCode/BD/BadVaddr and sets EXL.
- `cp0_eret`  out  1  one-cycle pulse: CP0 clears EXL.
- `cp0_exc_code`, `cp0_epc_wdata`, `cp0_bd`, `cp0_badvaddr`, `cp0_badv_wen`  out  5/32/1/32/1  values committed with `cp0_commit`.
- `div_abort`  out  1  divider abort pulse (only with `EXC_CTRL_DIV_ABORT_EN`).
- `redirect_valid`  out  1  redirect offered to IF.
- `redirect_pc`  out  32  redirect target.

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE: the event is taken when `mem_valid` and any of `int_pending`, `exc_req` or `eret_req` is high. Priority is interrupt > synchronous exception > ERET. The event's kind, code, BD, bad address and PC are captured.
  - Interrupt: code 5'h00, no BadVaddr write.
  - EPC value = `mem_bd ? mem_pc-4 : mem_pc`.
  - Target = `EXC_VECTOR`, or `cp0_epc` for ERET, sampled at capture.
- The next state is DRAIN if the outstanding count is nonzero or `div_busy` is high; otherwise COMMIT.
- DRAIN: stays until the count is 0 and `div_busy` is low, then goes to COMMIT. `mem_done` keeps decrementing the count.
- COMMIT: lasts exactly one cycle and then goes to REDIRECT.
  - `flush` pulses.
  - For an exception or interrupt, `cp0_commit` pulses; `cp0_badv_wen` equals the captured bad-address flag.
  - For ERET, `cp0_eret` pulses.
- REDIRECT: `redirect_valid` is held high with a stable `redirect_pc` until `redirect_ready`. The state returns to IDLE on the handshake cycle.
- Outstanding counter:
  - +1 on `mem_issue`, -1 on `mem_done`; both in the same cycle leaves it unchanged.
  - `mem_issue` at max, or `mem_done` at 0, is ignored and the counter holds.
- `mem_issue_block` = (state != IDLE) | (count == max).
- While `busy`, new `exc_req`, `int_pending` and `eret_req` are ignored.

## Timing
- Reset values: state IDLE, count 0; every output 0 except `redirect_pc`, which is `EXC_VECTOR`.
- Reset asserted mid-operation aborts the sequence immediately with no pulse emitted.
- Capture edge to `flush`:
  - 1 cycle with no drain (`flush` is high in the cycle after capture).
  - With a drain, `flush` follows 1 cycle after the edge where the drain condition is met.
- `redirect_valid` rises the cycle after `flush`.
- Minimum IDLE→IDLE turnaround is 3 cycles.
- `busy` is registered from the state and is high from the cycle after capture until the cycle after the handshake.
- All pulse outputs are decoded from registered state, so they are glitch-free.

## Configuration
- `EXC_CTRL_DIV_ABORT_EN` defined:
  - On DRAIN entry with `div_busy` high, `div_abort` pulses for one cycle.
  - DRAIN then waits only on the outstanding count; `div_busy` is ignored.
- Undefined: `div_abort` is tied 0 and DRAIN waits for `div_busy` to fall.

## Structure
- Package `exc_ctrl_pkg`:
  - State encoding typedef.
  - Event-kind typedef (INT/EXC/ERET).
  - ExcCode constants: INT 5'h00, ADEL 5'h04, ADES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c.
  - Default vector 32'hBFC00380.
- Sub-module `exc_outst_counter`: saturating up/down counter that outputs count, zero and full.

## Test plan
- `exc_req`, code 5'h0a, `mem_pc`=32'h8000_0010, bd=0, count 0 → `flush` and `cp0_commit` pulse 1 cycle later with code 5'h0a and EPC 32'h8000_0010; `redirect_pc` = 32'hBFC00380.
- `int_pending` together with `exc_req` (code 5'h0c), bd=1, pc=32'h8000_0024 → code 5'h00, EPC 32'h8000_0020, `cp0_bd`=1.
- AdEL with badvaddr 32'h0000_0003 and 2 outstanding → DRAIN lasts until the 2nd `mem_done`; then `cp0_badv_wen`=1 and `cp0_badvaddr`=32'h0000_0003; `mem_issue_block` is high throughout.
- `eret_req` with `cp0_epc`=32'h8000_0100 and `redirect_ready` held low 4 cycles → `cp0_eret` pulses, no `cp0_commit`, `redirect_valid` held 4 cycles then handshake, then IDLE.
- Counter: 7 issues (OUTST_W=3) → `mem_issue_block`=1, and an 8th issue is ignored; simultaneous `mem_issue`+`mem_done` leaves the count unchanged.
- `reset` pulsed while in DRAIN → next cycle IDLE, count 0, no `flush`; with `EXC_CTRL_DIV_ABORT_EN`, a `div_busy` exception produces a one-cycle `div_abort` on DRAIN entry.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/flush controller.
// Holds the FSM state encoding, event kinds, MIPS ExcCodes and the EPC helper.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } exc_state_t;

    typedef enum logic [1:0] {
        EV_INT,
        EV_EXC,
        EV_ERET
    } exc_kind_t;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_outst_counter.sv
// Saturating up/down counter of outstanding data-SRAM transactions.
// An issue and a response in the same cycle cancel; overflow/underflow attempts hold.
module exc_outst_counter #(
    parameter int OUTST_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [OUTST_W-1:0] o_count,
    output logic               o_zero,
    output logic               o_full
);

    localparam logic [OUTST_W-1:0] CNT_MAX = {OUTST_W{1'b1}};

    logic [OUTST_W-1:0] r_count;

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_full  = (r_count == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_full) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && !o_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/interrupt/ERET redirect sequencer: block issue, drain, commit CP0, flush, redirect IF.
// Optional EXC_CTRL_DIV_ABORT_EN: abort the divider on drain entry instead of waiting for it.
module exc_flush_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          OUTST_W    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        exc_badv_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic        int_pending,
    input  logic        eret_req,
    input  logic [31:0] cp0_epc,
    input  logic        mem_issue,
    input  logic        mem_done,
    input  logic        div_busy,
    input  logic        redirect_ready,
    output logic        busy,
    output logic        mem_issue_block,
    output logic        flush,
    output logic        cp0_commit,
    output logic        cp0_eret,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_epc_wdata,
    output logic        cp0_bd,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_badv_wen,
    output logic        div_abort,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    exc_state_t         r_state;
    exc_state_t         w_next_state;
    exc_kind_t          r_kind;
    logic [4:0]         r_code;
    logic [31:0]        r_epc;
    logic               r_bd;
    logic               r_badv_valid;
    logic [31:0]        r_badvaddr;
    logic [31:0]        r_target;

    logic [OUTST_W-1:0] w_count;
    logic               w_zero;
    logic               w_full;
    logic               w_take;
    logic               w_need_drain;
    logic               w_drain_done;

    exc_outst_counter #(
        .OUTST_W (OUTST_W)
    ) u_outst (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (mem_issue),
        .i_dec   (mem_done),
        .o_count (w_count),
        .o_zero  (w_zero),
        .o_full  (w_full)
    );

    assign w_take       = (r_state == ST_IDLE) && mem_valid && (int_pending || exc_req || eret_req);
    assign w_need_drain = (w_count != '0) || div_busy;

`ifdef EXC_CTRL_DIV_ABORT_EN
    logic r_div_abort;

    // The divider is killed on drain entry, so draining only waits on memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_abort <= 1'b0;
        end else begin
            r_div_abort <= w_take && w_need_drain && div_busy;
        end
    end

    assign div_abort    = r_div_abort;
    assign w_drain_done = w_zero;
`else
    assign div_abort    = 1'b0;
    assign w_drain_done = w_zero && !div_busy;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_take) w_next_state = w_need_drain ? ST_DRAIN : ST_COMMIT;
            ST_DRAIN:    if (w_drain_done) w_next_state = ST_COMMIT;
            ST_COMMIT:   w_next_state = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Event context is frozen at capture so CP0 and IF see values from the faulting instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind       <= EV_INT;
            r_code       <= 5'h00;
            r_epc        <= 32'h0;
            r_bd         <= 1'b0;
            r_badv_valid <= 1'b0;
            r_badvaddr   <= 32'h0;
            r_target     <= EXC_VECTOR;
        end else if (w_take) begin
            r_epc      <= epc_of(mem_pc, mem_bd);
            r_bd       <= mem_bd;
            r_badvaddr <= exc_badvaddr;
            if (int_pending) begin
                r_kind       <= EV_INT;
                r_code       <= EXCCODE_INT;
                r_badv_valid <= 1'b0;
                r_target     <= EXC_VECTOR;
            end else if (exc_req) begin
                r_kind       <= EV_EXC;
                r_code       <= exc_code;
                r_badv_valid <= exc_badv_valid;
                r_target     <= EXC_VECTOR;
            end else begin
                r_kind       <= EV_ERET;
                r_code       <= EXCCODE_INT;
                r_badv_valid <= 1'b0;
                r_target     <= cp0_epc;
            end
        end
    end

    always_comb begin
        busy            = (r_state != ST_IDLE);
        mem_issue_block = (r_state != ST_IDLE) || w_full;
        flush           = (r_state == ST_COMMIT);
        cp0_commit      = (r_state == ST_COMMIT) && (r_kind != EV_ERET);
        cp0_eret        = (r_state == ST_COMMIT) && (r_kind == EV_ERET);
        cp0_badv_wen    = (r_state == ST_COMMIT) && r_badv_valid;
        cp0_exc_code    = r_code;
        cp0_epc_wdata   = r_epc;
        cp0_bd          = r_bd;
        cp0_badvaddr    = r_badvaddr;
        redirect_valid  = (r_state == ST_REDIRECT);
        redirect_pc     = r_target;
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Self-checking bench for exc_flush_ctrl: directed scenarios plus random traffic against a phase-level model.
// Honours EXC_CTRL_DIV_ABORT_EN when the design is built with it.
module tb_exc_flush_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC00380;
    localparam int          MAXC = 7;
`ifdef EXC_CTRL_DIV_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_bd, exc_req, exc_badv_valid, int_pending, eret_req;
    logic [31:0] mem_pc, exc_badvaddr, cp0_epc;
    logic [4:0]  exc_code;
    logic        mem_issue, mem_done, div_busy, redirect_ready;
    logic        busy, mem_issue_block, flush, cp0_commit, cp0_eret, cp0_bd, cp0_badv_wen;
    logic        div_abort, redirect_valid;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_epc_wdata, cp0_badvaddr, redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: sequence phase as text, outstanding count and captured event.
    string       mPhase;
    int          mCount;
    bit          mIsEret, mBd, mBadvFlag, mAbort;
    logic [4:0]  mCode;
    logic [31:0] mEpc, mBadv, mTarget;

    always #5 clk = ~clk;

    exc_flush_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_pc          (mem_pc),
        .mem_bd          (mem_bd),
        .exc_req         (exc_req),
        .exc_code        (exc_code),
        .exc_badv_valid  (exc_badv_valid),
        .exc_badvaddr    (exc_badvaddr),
        .int_pending     (int_pending),
        .eret_req        (eret_req),
        .cp0_epc         (cp0_epc),
        .mem_issue       (mem_issue),
        .mem_done        (mem_done),
        .div_busy        (div_busy),
        .redirect_ready  (redirect_ready),
        .busy            (busy),
        .mem_issue_block (mem_issue_block),
        .flush           (flush),
        .cp0_commit      (cp0_commit),
        .cp0_eret        (cp0_eret),
        .cp0_exc_code    (cp0_exc_code),
        .cp0_epc_wdata   (cp0_epc_wdata),
        .cp0_bd          (cp0_bd),
        .cp0_badvaddr    (cp0_badvaddr),
        .cp0_badv_wen    (cp0_badv_wen),
        .div_abort       (div_abort),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    task automatic modelReset();
        mPhase    = "idle";
        mCount    = 0;
        mIsEret   = 1'b0;
        mBd       = 1'b0;
        mBadvFlag = 1'b0;
        mAbort    = 1'b0;
        mCode     = 5'h00;
        mEpc      = 32'h0;
        mBadv     = 32'h0;
        mTarget   = VEC;
    endtask

    task automatic applyIdleInputs();
        mem_valid      = 1'b0;
        mem_pc         = 32'h0;
        mem_bd         = 1'b0;
        exc_req        = 1'b0;
        exc_code       = 5'h00;
        exc_badv_valid = 1'b0;
        exc_badvaddr   = 32'h0;
        int_pending    = 1'b0;
        eret_req       = 1'b0;
        cp0_epc        = 32'h0;
        mem_issue      = 1'b0;
        mem_done       = 1'b0;
        div_busy       = 1'b0;
        redirect_ready = 1'b0;
    endtask

    // One clock: the model consumes the inputs present at the edge, outputs are then sampled at negedge.
    task automatic step();
        string nxt;
        int    c;
        bit    abortNext;
        @(posedge clk);
        nxt       = mPhase;
        c         = mCount;
        abortNext = 1'b0;
        if (mPhase == "idle") begin
            if (mem_valid && (int_pending || exc_req || eret_req)) begin
                mEpc  = mem_bd ? mem_pc - 32'd4 : mem_pc;
                mBd   = mem_bd;
                mBadv = exc_badvaddr;
                if (int_pending) begin
                    mIsEret = 1'b0; mCode = 5'h00; mBadvFlag = 1'b0; mTarget = VEC;
                end else if (exc_req) begin
                    mIsEret = 1'b0; mCode = exc_code; mBadvFlag = exc_badv_valid; mTarget = VEC;
                end else begin
                    mIsEret = 1'b1; mCode = 5'h00; mBadvFlag = 1'b0; mTarget = cp0_epc;
                end
                if (c != 0 || div_busy) nxt = "drain";
                else nxt = "commit";
                abortNext = ABORT_EN && div_busy;
            end
        end else if (mPhase == "drain") begin
            if (c == 0 && (ABORT_EN || !div_busy)) nxt = "commit";
        end else if (mPhase == "commit") begin
            nxt = "redirect";
        end else if (redirect_ready) begin
            nxt = "idle";
        end
        if (mem_issue && !mem_done && c < MAXC) c++;
        else if (mem_done && !mem_issue && c > 0) c--;
        mPhase = nxt;
        mCount = c;
        mAbort = abortNext;
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyIdleInputs();
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, mem_issue_block, flush, cp0_commit, cp0_eret, cp0_badv_wen, div_abort, redirect_valid} !== 8'h00)
            begin errors++; $display("[TB] FAIL reset_ctl got=%b want=00000000", {busy, mem_issue_block, flush, cp0_commit, cp0_eret, cp0_badv_wen, div_abort, redirect_valid}); end
        checks++;
        if ({cp0_exc_code, cp0_epc_wdata, cp0_bd, cp0_badvaddr} !== 70'h0)
            begin errors++; $display("[TB] FAIL reset_cp0 got=%h want=0", {cp0_exc_code, cp0_epc_wdata, cp0_bd, cp0_badvaddr}); end
        checks++;
        if (redirect_pc !== VEC) begin errors++; $display("[TB] FAIL reset_pc got=%h want=%h", redirect_pc, VEC); end
        reset = 1'b0;
    endtask

    task automatic test_exception();
        applyIdleInputs();
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h0a; mem_pc = 32'h8000_0010; mem_bd = 1'b0;
        step();
        applyIdleInputs();
        checks++;
        if ({flush, cp0_commit, cp0_eret, cp0_badv_wen, busy} !== 5'b11001)
            begin errors++; $display("[TB] FAIL exc_pulses got=%b want=11001", {flush, cp0_commit, cp0_eret, cp0_badv_wen, busy}); end
        checks++;
        if (cp0_exc_code !== 5'h0a) begin errors++; $display("[TB] FAIL exc_code got=%h want=0a", cp0_exc_code); end
        checks++;
        if (cp0_epc_wdata !== 32'h8000_0010) begin errors++; $display("[TB] FAIL exc_epc got=%h want=80000010", cp0_epc_wdata); end
        step();
        checks++;
        if ({redirect_valid, flush, cp0_commit} !== 3'b100)
            begin errors++; $display("[TB] FAIL exc_redirect got=%b want=100", {redirect_valid, flush, cp0_commit}); end
        checks++;
        if (redirect_pc !== VEC) begin errors++; $display("[TB] FAIL exc_target got=%h want=%h", redirect_pc, VEC); end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        checks++;
        if ({busy, redirect_valid} !== 2'b00) begin errors++; $display("[TB] FAIL exc_return got=%b want=00", {busy, redirect_valid}); end
    endtask

    task automatic test_int_priority();
        applyIdleInputs();
        mem_valid = 1'b1; int_pending = 1'b1; exc_req = 1'b1; exc_code = 5'h0c;
        exc_badv_valid = 1'b1; mem_bd = 1'b1; mem_pc = 32'h8000_0024;
        step();
        applyIdleInputs();
        checks++;
        if (cp0_exc_code !== 5'h00) begin errors++; $display("[TB] FAIL int_code got=%h want=00", cp0_exc_code); end
        checks++;
        if (cp0_epc_wdata !== 32'h8000_0020) begin errors++; $display("[TB] FAIL int_epc got=%h want=80000020", cp0_epc_wdata); end
        checks++;
        if ({cp0_bd, cp0_commit, cp0_badv_wen} !== 3'b110)
            begin errors++; $display("[TB] FAIL int_flags got=%b want=110", {cp0_bd, cp0_commit, cp0_badv_wen}); end
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL int_return got=%b want=0", busy); end
    endtask

    task automatic test_drain();
        bit seen = 1'b0;
        applyIdleInputs();
        mem_issue = 1'b1;
        step();
        step();
        mem_issue = 1'b0;
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h04; exc_badv_valid = 1'b1;
        exc_badvaddr = 32'h0000_0003; mem_pc = 32'h8000_0040;
        step();
        applyIdleInputs();
        checks++;
        if ({busy, mem_issue_block, flush} !== 3'b110)
            begin errors++; $display("[TB] FAIL drain_entry got=%b want=110", {busy, mem_issue_block, flush}); end
        mem_done = 1'b1;
        step();
        checks++;
        if ({mem_issue_block, flush} !== 2'b10)
            begin errors++; $display("[TB] FAIL drain_first_done got=%b want=10", {mem_issue_block, flush}); end
        step();
        mem_done = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            checks++;
            if (flush !== (mPhase == "commit"))
                begin errors++; $display("[TB] FAIL drain_flush_timing got=%b want=%b", flush, mPhase == "commit"); end
            if (flush === 1'b1) begin
                seen = 1'b1;
                checks++;
                if ({cp0_badv_wen, cp0_badvaddr, cp0_exc_code, mem_issue_block} !== {1'b1, 32'h0000_0003, 5'h04, 1'b1})
                    begin errors++; $display("[TB] FAIL drain_commit got=%h want=%h", {cp0_badv_wen, cp0_badvaddr, cp0_exc_code, mem_issue_block}, {1'b1, 32'h0000_0003, 5'h04, 1'b1}); end
            end else begin
                checks++;
                if (mem_issue_block !== 1'b1) begin errors++; $display("[TB] FAIL drain_block got=%b want=1", mem_issue_block); end
                step();
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout got=no_flush want=flush");
        end
        step();
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
    endtask

    task automatic test_eret();
        applyIdleInputs();
        mem_valid = 1'b1; eret_req = 1'b1; cp0_epc = 32'h8000_0100; mem_pc = 32'h8000_0080;
        step();
        applyIdleInputs();
        cp0_epc = 32'h1234_5678;
        checks++;
        if ({flush, cp0_eret, cp0_commit, cp0_badv_wen} !== 4'b1100)
            begin errors++; $display("[TB] FAIL eret_pulses got=%b want=1100", {flush, cp0_eret, cp0_commit, cp0_badv_wen}); end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin mem_valid = 1'b1; exc_req = 1'b1; int_pending = 1'b1; end
            step();
            checks++;
            if ({redirect_valid, redirect_pc, flush, cp0_commit} !== {1'b1, 32'h8000_0100, 1'b0, 1'b0})
                begin errors++; $display("[TB] FAIL eret_hold got=%h want=%h", {redirect_valid, redirect_pc, flush, cp0_commit}, {1'b1, 32'h8000_0100, 1'b0, 1'b0}); end
        end
        applyIdleInputs();
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        checks++;
        if ({busy, redirect_valid} !== 2'b00) begin errors++; $display("[TB] FAIL eret_return got=%b want=00", {busy, redirect_valid}); end
    endtask

    task automatic test_counter();
        applyIdleInputs();
        for (int i = 1; i <= 8; i++) begin
            mem_issue = 1'b1;
            step();
            checks++;
            if (mem_issue_block !== (i >= 7))
                begin errors++; $display("[TB] FAIL cnt_issue_%0d got=%b want=%b", i, mem_issue_block, i >= 7); end
        end
        mem_done = 1'b1;
        step();
        checks++;
        if (mem_issue_block !== 1'b1) begin errors++; $display("[TB] FAIL cnt_simultaneous got=%b want=1", mem_issue_block); end
        mem_issue = 1'b0;
        step();
        checks++;
        if (mem_issue_block !== 1'b0) begin errors++; $display("[TB] FAIL cnt_dec_from_max got=%b want=0", mem_issue_block); end
        for (int i = 0; i < 8; i++) step();
        mem_done = 1'b0;
        checks++;
        if (mem_issue_block !== 1'b0) begin errors++; $display("[TB] FAIL cnt_underflow got=%b want=0", mem_issue_block); end
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h08;
        step();
        applyIdleInputs();
        checks++;
        if (flush !== 1'b1) begin errors++; $display("[TB] FAIL cnt_zero_nodrain got=%b want=1", flush); end
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        applyIdleInputs();
        mem_issue = 1'b1;
        step();
        mem_issue = 1'b0;
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h0c;
        step();
        applyIdleInputs();
        checks++;
        if ({busy, flush} !== 2'b10) begin errors++; $display("[TB] FAIL rst_pre_drain got=%b want=10", {busy, flush}); end
        reset = 1'b1;
        #1;
        modelReset();
        checks++;
        if ({busy, mem_issue_block, flush, cp0_commit, redirect_valid} !== 5'b00000)
            begin errors++; $display("[TB] FAIL rst_abort got=%b want=00000", {busy, mem_issue_block, flush, cp0_commit, redirect_valid}); end
        #2;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({busy, flush, cp0_commit, redirect_valid} !== 4'b0000)
                begin errors++; $display("[TB] FAIL rst_quiet got=%b want=0000", {busy, flush, cp0_commit, redirect_valid}); end
        end
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h09;
        step();
        applyIdleInputs();
        checks++;
        if (flush !== 1'b1) begin errors++; $display("[TB] FAIL rst_count_cleared got=%b want=1", flush); end
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
    endtask

    task automatic test_div();
        applyIdleInputs();
        mem_valid = 1'b1; exc_req = 1'b1; exc_code = 5'h0c; div_busy = 1'b1;
        step();
        mem_valid = 1'b0; exc_req = 1'b0;
`ifdef EXC_CTRL_DIV_ABORT_EN
        checks++;
        if ({div_abort, busy, flush} !== 3'b110) begin errors++; $display("[TB] FAIL div_abort_pulse got=%b want=110", {div_abort, busy, flush}); end
        step();
        checks++;
        if ({div_abort, flush} !== 2'b01) begin errors++; $display("[TB] FAIL div_abort_commit got=%b want=01", {div_abort, flush}); end
`else
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({div_abort, busy, flush} !== 3'b010) begin errors++; $display("[TB] FAIL div_wait got=%b want=010", {div_abort, busy, flush}); end
            step();
        end
        div_busy = 1'b0;
        step();
        checks++;
        if (flush !== 1'b1) begin errors++; $display("[TB] FAIL div_release got=%b want=1", flush); end
`endif
        applyIdleInputs();
        redirect_ready = 1'b1;
        step();
        step();
        redirect_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0]  codes [7] = '{5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h00};
        logic [31:0] r;
        logic [7:0]  expCtl, gotCtl;
        bit          expBusy, expCommit;
        for (int n = 0; n < 1500; n++) begin
            expBusy   = (mPhase != "idle");
            expCommit = (mPhase == "commit");
            expCtl = {expBusy, expBusy || (mCount == MAXC), expCommit, expCommit && !mIsEret,
                      expCommit && mIsEret, mAbort, mPhase == "redirect", expCommit && mBadvFlag};
            gotCtl = {busy, mem_issue_block, flush, cp0_commit, cp0_eret, div_abort, redirect_valid, cp0_badv_wen};
            checks++;
            if (gotCtl !== expCtl) begin errors++; $display("[TB] FAIL rnd_ctl cycle %0d got=%b want=%b", n, gotCtl, expCtl); end
            checks++;
            if (redirect_pc !== mTarget) begin errors++; $display("[TB] FAIL rnd_target cycle %0d got=%h want=%h", n, redirect_pc, mTarget); end
            if (expCommit && !mIsEret) begin
                checks++;
                if ({cp0_exc_code, cp0_epc_wdata, cp0_bd} !== {mCode, mEpc, mBd})
                    begin errors++; $display("[TB] FAIL rnd_cp0 cycle %0d got=%h want=%h", n, {cp0_exc_code, cp0_epc_wdata, cp0_bd}, {mCode, mEpc, mBd}); end
                if (mBadvFlag) begin
                    checks++;
                    if (cp0_badvaddr !== mBadv) begin errors++; $display("[TB] FAIL rnd_badv cycle %0d got=%h want=%h", n, cp0_badvaddr, mBadv); end
                end
            end
            r              = $urandom();
            mem_pc         = {r[31:2], 2'b00};
            mem_valid      = ($urandom_range(0, 1) == 1);
            mem_bd         = ($urandom_range(0, 1) == 1);
            int_pending    = ($urandom_range(0, 9) == 0);
            exc_req        = ($urandom_range(0, 4) == 0);
            eret_req       = ($urandom_range(0, 6) == 0);
            exc_code       = codes[$urandom_range(0, 6)];
            exc_badv_valid = ($urandom_range(0, 1) == 1);
            exc_badvaddr   = $urandom();
            cp0_epc        = $urandom();
            mem_issue      = ($urandom_range(0, 2) == 0);
            mem_done       = ($urandom_range(0, 2) == 0);
            div_busy       = ($urandom_range(0, 3) == 0);
            redirect_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        applyIdleInputs();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_exception();
        test_int_priority();
        test_drain();
        test_eret();
        test_counter();
        test_reset_mid_drain();
        test_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
